// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore FSM control unit for a multi-cycle MIPS datapath with a
//               shared instruction/data memory. One state per cycle, stalls on
//               MemReady, optional bounded wait with a MemTimeout pulse.
//               Define CTRL_JAL_EN to decode opcode 0x03 as JAL.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int ALUOP_WIDTH = 3,
    parameter int WAIT_LIMIT  = 0,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             OP,
    input  logic                   MemReady,
    output logic                   PCWrite,
    output logic                   BranchEQ,
    output logic                   BranchNE,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   MemtoReg,
    output logic [1:0]             RegDst,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSource,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   IllegalOp,
    output logic                   MemTimeout
);

    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(3'b100);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(3'b001);
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR    = ALUOP_WIDTH'(3'b101);
    localparam logic [ALUOP_WIDTH-1:0] ALU_AND   = ALUOP_WIDTH'(3'b010);
    localparam logic [ALUOP_WIDTH-1:0] ALU_LUI   = ALUOP_WIDTH'(3'b110);
    localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = ALUOP_WIDTH'(3'b111);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU, S_EXEC_I, S_WB_IMM,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           op_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q;
    logic                 w_is_mem;
    logic                 w_timeout;

    // States that wait on the memory handshake
    assign w_is_mem = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    generate
        if (WAIT_LIMIT > 0) begin : g_timeout
            assign w_timeout = w_is_mem && !MemReady && (cnt_q == CNT_WIDTH'(WAIT_LIMIT));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign IllegalOp  = illegal_q;
    assign MemTimeout = timeout_q;

    // State, latched opcode, wait counter and the registered pulse outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RESET;
            op_q      <= 6'h00;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= w_timeout;
            if (state_q == S_DECODE) begin
                op_q <= OP;
            end
        end
    end

    // Next state, wait counter update and illegal-opcode detection
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        // Counter only runs while stalled in a memory state; any exit
        // (completion or timeout) clears it so the next access starts at 0.
        cnt_d     = '0;
        if (w_is_mem && !MemReady && !w_timeout) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
        case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    if (MemReady) state_d = S_DECODE;
                        else if (w_timeout) state_d = S_FETCH;
            S_DECODE: begin
                case (OP)
                    6'h00:                      state_d = S_EXEC_R;
                    6'h08, 6'h0d, 6'h0c, 6'h0f: state_d = S_EXEC_I;
                    6'h23, 6'h2b:               state_d = S_MEM_ADDR;
                    6'h04, 6'h05:               state_d = S_BRANCH;
                    6'h02:                      state_d = S_JUMP;
`ifdef CTRL_JAL_EN
                    6'h03:                      state_d = S_JAL;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R:   state_d = S_WB_ALU;
            S_EXEC_I:   state_d = S_WB_IMM;
            S_MEM_ADDR: state_d = (op_q == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (MemReady) state_d = S_MEM_WB;
                        else if (w_timeout) state_d = S_FETCH;
            S_MEM_WR:   if (MemReady || w_timeout) state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Control outputs decoded from state and latched opcode only; the sole
    // input term is MemReady qualifying the FETCH-cycle PC/IR loads, so a
    // stalled or timed-out fetch never commits.
    always_comb begin
        PCWrite  = 1'b0;
        BranchEQ = 1'b0;
        BranchNE = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 2'd0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'd0;
        PCSource = 2'd0;
        ALUOp    = '0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
                ALUSrcB = 2'd1;
                ALUOp   = ALU_ADD;
            end
            S_DECODE: begin
                ALUSrcB = 2'd3;
                ALUOp   = ALU_ADD;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_WB_ALU: begin
                RegDst   = 2'd1;
                RegWrite = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                case (op_q)
                    6'h0d:   ALUOp = ALU_OR;
                    6'h0c:   ALUOp = ALU_AND;
                    6'h0f:   ALUOp = ALU_LUI;
                    default: ALUOp = ALU_ADD;
                endcase
            end
            S_WB_IMM:   RegWrite = 1'b1;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                ALUOp   = ALU_ADD;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSource = 2'd1;
                BranchEQ = (op_q == 6'h04);
                BranchNE = (op_q == 6'h05);
            end
            S_JUMP: begin
                PCSource = 2'd2;
                PCWrite  = 1'b1;
            end
`ifdef CTRL_JAL_EN
            // PC already holds PC+4 from FETCH; the ALU recomputes nothing
            // useful here, the link value is routed as PC+4 into $31.
            S_JAL: begin
                PCSource = 2'd2;
                PCWrite  = 1'b1;
                RegDst   = 2'd2;
                RegWrite = 1'b1;
                ALUSrcB  = 2'd1;
                ALUOp    = ALU_ADD;
            end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control. Inputs
//               change on the falling edge, outputs are compared 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n, rst2_n;
    logic [5:0] op, op2;
    logic       mr, mr2;
    int         ncmp = 0;
    int         nfail = 0;

    logic       pcw, beq, bne, iord, mrd, mwr, irw, m2r, rw, asa, ill, to;
    logic [1:0] rdst, asb, pcs;
    logic [2:0] aop;
    logic       pcw2, beq2, bne2, iord2, mrd2, mwr2, irw2, m2r2, rw2, asa2, ill2, to2;
    logic [1:0] rdst2, asb2, pcs2;
    logic [2:0] aop2;

    wire [20:0] outs  = {pcw, beq, bne, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, pcs, aop, ill, to};
    wire [20:0] outs2 = {pcw2, beq2, bne2, iord2, mrd2, mwr2, irw2, m2r2, rdst2, rw2, asa2, asb2, pcs2, aop2, ill2, to2};

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(rst_n), .OP(op), .MemReady(mr),
        .PCWrite(pcw), .BranchEQ(beq), .BranchNE(bne), .IorD(iord), .MemRead(mrd),
        .MemWrite(mwr), .IRWrite(irw), .MemtoReg(m2r), .RegDst(rdst), .RegWrite(rw),
        .ALUSrcA(asa), .ALUSrcB(asb), .PCSource(pcs), .ALUOp(aop),
        .IllegalOp(ill), .MemTimeout(to)
    );

    multicycle_control #(.WAIT_LIMIT(3)) dut_to (
        .clk(clk), .reset(rst2_n), .OP(op2), .MemReady(mr2),
        .PCWrite(pcw2), .BranchEQ(beq2), .BranchNE(bne2), .IorD(iord2), .MemRead(mrd2),
        .MemWrite(mwr2), .IRWrite(irw2), .MemtoReg(m2r2), .RegDst(rdst2), .RegWrite(rw2),
        .ALUSrcA(asa2), .ALUSrcB(asb2), .PCSource(pcs2), .ALUOp(aop2),
        .IllegalOp(ill2), .MemTimeout(to2)
    );

    // Packs one hand-written control word in the same order as outs
    function automatic logic [20:0] pk(input logic p, be, bn, io, rd, wr, ir, mt,
                                       input logic [1:0] dst, input logic w, sa,
                                       input logic [1:0] sb, ps, input logic [2:0] ao,
                                       input logic il, tmo);
        return {p, be, bn, io, rd, wr, ir, mt, dst, w, sa, sb, ps, ao, il, tmo};
    endfunction

    logic [20:0] E_ZERO, E_FETCH, E_FSTALL, E_DECODE, E_EXR, E_WBALU, E_WBIMM, E_MADDR,
                 E_MRD, E_MWB, E_MWR, E_BEQ, E_BNE, E_JMP, E_JAL;

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            ncmp++;
            if (outs !== E_ZERO) begin nfail++; $display("FAIL reset cyc%0d: got %h expected %h", i, outs, E_ZERO); end
        end
        rst_n = 1'b1; #1;
        ncmp++;
        if (outs !== E_ZERO) begin nfail++; $display("FAIL reset_release: got %h expected %h", outs, E_ZERO); end
    endtask

    // OP is scrambled outside DECODE to show it is ignored there
    task automatic test_r_type();
        logic [20:0] e [4];
        logic [5:0]  o [4];
        e = '{E_FETCH, E_DECODE, E_EXR, E_WBALU};
        o = '{6'h3f, 6'h00, 6'h23, 6'h05};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); op = o[i]; mr = 1'b1; #1;
            ncmp++;
            if (outs !== e[i]) begin nfail++; $display("FAIL r_type cyc%0d: got %h expected %h", i, outs, e[i]); end
        end
    endtask

    task automatic test_i_type();
        logic [5:0] ops [4];
        logic [2:0] alu [4];
        logic [20:0] e [4];
        ops = '{6'h08, 6'h0d, 6'h0c, 6'h0f};
        alu = '{3'b100, 3'b101, 3'b010, 3'b110};
        for (int k = 0; k < 4; k++) begin
            e = '{E_FETCH, E_DECODE, pk(0,0,0,0,0,0,0,0,2'd0,0,1,2'd2,2'd0,alu[k],0,0), E_WBIMM};
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); op = (i == 1) ? ops[k] : 6'h00; mr = 1'b1; #1;
                ncmp++;
                if (outs !== e[i]) begin nfail++; $display("FAIL i_type op%h cyc%0d: got %h expected %h", ops[k], i, outs, e[i]); end
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [20:0] e [7];
        logic        m [7];
        e = '{E_FETCH, E_DECODE, E_MADDR, E_MRD, E_MRD, E_MRD, E_MWB};
        m = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); op = 6'h23; mr = m[i]; #1;
            ncmp++;
            if (outs !== e[i]) begin nfail++; $display("FAIL lw_wait cyc%0d: got %h expected %h", i, outs, e[i]); end
        end
    endtask

    task automatic test_sw_fetch_stall();
        logic [20:0] e [5];
        logic        m [5];
        e = '{E_FSTALL, E_FETCH, E_DECODE, E_MADDR, E_MWR};
        m = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); op = 6'h2b; mr = m[i]; #1;
            ncmp++;
            if (outs !== e[i]) begin nfail++; $display("FAIL sw_stall cyc%0d: got %h expected %h", i, outs, e[i]); end
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0]  ops [3];
        logic [20:0] last [3];
        ops  = '{6'h04, 6'h05, 6'h02};
        last = '{E_BEQ, E_BNE, E_JMP};
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); op = (i == 1) ? ops[k] : 6'h3f; mr = 1'b1; #1;
                ncmp++;
                if (outs !== ((i == 0) ? E_FETCH : (i == 1) ? E_DECODE : last[k])) begin
                    nfail++;
                    $display("FAIL branch op%h cyc%0d: got %h expected %h", ops[k], i, outs,
                             (i == 0) ? E_FETCH : (i == 1) ? E_DECODE : last[k]);
                end
            end
        end
    endtask

    // Third cycle stalls FETCH so the following FETCH shows the pulse has ended
    task automatic test_illegal(input logic [5:0] code);
        logic [20:0] e [3];
        logic        m [3];
        e = '{E_FETCH, E_DECODE, E_FSTALL | 21'h2};
        m = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); op = code; mr = m[i]; #1;
            ncmp++;
            if (outs !== e[i]) begin nfail++; $display("FAIL illegal op%h cyc%0d: got %h expected %h", code, i, outs, e[i]); end
        end
    endtask

    task automatic test_jal();
`ifdef CTRL_JAL_EN
        logic [20:0] e [3];
        e = '{E_FETCH, E_DECODE, E_JAL};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); op = 6'h03; mr = 1'b1; #1;
            ncmp++;
            if (outs !== e[i]) begin nfail++; $display("FAIL jal cyc%0d: got %h expected %h", i, outs, e[i]); end
        end
`else
        test_illegal(6'h03);
`endif
    endtask

    task automatic test_reset_midway();
        logic [20:0] e [4];
        logic        m [4];
        e = '{E_FETCH, E_DECODE, E_MADDR, E_MWR};
        m = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); op = 6'h2b; mr = m[i]; #1;
            ncmp++;
            if (outs !== e[i]) begin nfail++; $display("FAIL midway cyc%0d: got %h expected %h", i, outs, e[i]); end
        end
        @(negedge clk); mr = 1'b1; rst_n = 1'b0; #1;
        ncmp++;
        if (outs !== E_ZERO) begin nfail++; $display("FAIL midway_async: got %h expected %h", outs, E_ZERO); end
        @(negedge clk); #1;
        ncmp++;
        if (outs !== E_ZERO) begin nfail++; $display("FAIL midway_hold: got %h expected %h", outs, E_ZERO); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        ncmp++;
        if (outs !== E_FETCH) begin nfail++; $display("FAIL midway_refetch: got %h expected %h", outs, E_FETCH); end
    endtask

    task automatic test_timeout();
        logic [20:0] e [17];
        logic        m [17];
        logic [5:0]  o [17];
        e = '{E_FSTALL, E_FSTALL, E_FSTALL, E_FSTALL, E_FSTALL | 21'h1, E_FSTALL, E_FSTALL,
              E_FETCH, E_DECODE, E_MADDR, E_MRD, E_MRD, E_MRD, E_MRD, E_FETCH | 21'h1,
              E_DECODE, E_JMP};
        m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        o = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h00,
              6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h00};
        @(negedge clk); rst2_n = 1'b1; mr2 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); op2 = o[i]; mr2 = m[i]; #1;
            ncmp++;
            if (outs2 !== e[i]) begin nfail++; $display("FAIL timeout cyc%0d: got %h expected %h", i, outs2, e[i]); end
        end
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        op = 6'h00; op2 = 6'h00; mr = 1'b1; mr2 = 1'b0;
        E_ZERO   = '0;
        E_FETCH  = pk(1,0,0,0,1,0,1,0,2'd0,0,0,2'd1,2'd0,3'b100,0,0);
        E_FSTALL = pk(0,0,0,0,1,0,0,0,2'd0,0,0,2'd1,2'd0,3'b100,0,0);
        E_DECODE = pk(0,0,0,0,0,0,0,0,2'd0,0,0,2'd3,2'd0,3'b100,0,0);
        E_EXR    = pk(0,0,0,0,0,0,0,0,2'd0,0,1,2'd0,2'd0,3'b111,0,0);
        E_WBALU  = pk(0,0,0,0,0,0,0,0,2'd1,1,0,2'd0,2'd0,3'b000,0,0);
        E_WBIMM  = pk(0,0,0,0,0,0,0,0,2'd0,1,0,2'd0,2'd0,3'b000,0,0);
        E_MADDR  = pk(0,0,0,0,0,0,0,0,2'd0,0,1,2'd2,2'd0,3'b100,0,0);
        E_MRD    = pk(0,0,0,1,1,0,0,0,2'd0,0,0,2'd0,2'd0,3'b000,0,0);
        E_MWB    = pk(0,0,0,0,0,0,0,1,2'd0,1,0,2'd0,2'd0,3'b000,0,0);
        E_MWR    = pk(0,0,0,1,0,1,0,0,2'd0,0,0,2'd0,2'd0,3'b000,0,0);
        E_BEQ    = pk(0,1,0,0,0,0,0,0,2'd0,0,1,2'd0,2'd1,3'b001,0,0);
        E_BNE    = pk(0,0,1,0,0,0,0,0,2'd0,0,1,2'd0,2'd1,3'b001,0,0);
        E_JMP    = pk(1,0,0,0,0,0,0,0,2'd0,0,0,2'd0,2'd2,3'b000,0,0);
        E_JAL    = pk(1,0,0,0,0,0,0,0,2'd2,1,0,2'd1,2'd2,3'b100,0,0);

        test_reset();
        test_r_type();
        test_i_type();
        test_lw_wait();
        test_sw_fetch_stall();
        test_branch_jump();
        test_illegal(6'h3f);
        test_jal();
        test_reset_midway();
        test_timeout();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
